// File: rtl/arb_2to1_if.sv
// Stream bundle for the 2:1 round-robin arbiter: two source channels,
// one registered output channel and the per-source grant counters.
interface arb_2to1_if #(
    parameter int N  = 8,
    parameter int CW = 8
);
    // source 0 channel
    logic [N-1:0]  in0_data;
    logic          in0_valid;
    logic          in0_ready;
    // source 1 channel
    logic [N-1:0]  in1_data;
    logic          in1_valid;
    logic          in1_ready;
    // output channel
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_src;
    // debug / fairness counters
    logic [CW-1:0] gnt_cnt0;
    logic [CW-1:0] gnt_cnt1;

    // arbiter side
    modport slave (
        input  in0_data, in0_valid,
        input  in1_data, in1_valid,
        input  out_ready,
        output in0_ready, in1_ready,
        output out_data, out_valid, out_src,
        output gnt_cnt0, gnt_cnt1
    );

    // sources + downstream sink side
    modport master (
        output in0_data, in0_valid,
        output in1_data, in1_valid,
        output out_ready,
        input  in0_ready, in1_ready,
        input  out_data, out_valid, out_src,
        input  gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/arb_2to1.sv
// Two-input round-robin stream arbiter with a registered output stage.
// One source wins per cycle; the winning word and its index are registered.
// The tie-break pointer flips to the loser after every grant, so two
// continuously valid sources alternate 0,1,0,1... starting with 0.
module arb_2to1 #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic        clk,
    input  logic        rst,     // synchronous, active-low
    arb_2to1_if.slave   bus
);

    // ------------------------------------------------------------------
    // state
    // ------------------------------------------------------------------
    logic [N-1:0]  out_data_q,  out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_src_q,   out_src_d;
    logic          prio_q,      prio_d;
    logic [CW-1:0] cnt0_q,      cnt0_d;
    logic [CW-1:0] cnt1_q,      cnt1_d;

    // ------------------------------------------------------------------
    // arbitration
    // ------------------------------------------------------------------
    logic load;      // output stage can take a word this cycle
    logic gnt_vld;   // some source wins this cycle
    logic gnt_sel;   // index of the winner (meaningful only with gnt_vld)

    // Grant decision: a lone requester wins, a tie goes to prio_q.
    // Readys are gated by rst so no handshake can complete in reset.
    always_comb begin
        load    = !out_valid_q || bus.out_ready;
        gnt_sel = 1'b0;
        gnt_vld = 1'b0;
        if (bus.in0_valid && bus.in1_valid) begin
            gnt_sel = prio_q;
        end else if (bus.in1_valid) begin
            gnt_sel = 1'b1;
        end
        if (rst && load && (bus.in0_valid || bus.in1_valid)) begin
            gnt_vld = 1'b1;
        end
    end

    assign bus.in0_ready = gnt_vld && (gnt_sel == 1'b0);
    assign bus.in1_ready = gnt_vld && (gnt_sel == 1'b1);

    // ------------------------------------------------------------------
    // next state
    // ------------------------------------------------------------------

    // Output register, pointer and counters: load on grant, clear valid on
    // an idle load (data/src keep their stale value), hold everything on stall.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        prio_d      = prio_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        if (load) begin
            if (gnt_vld) begin
                out_data_d  = gnt_sel ? bus.in1_data : bus.in0_data;
                out_src_d   = gnt_sel;
                out_valid_d = 1'b1;
                prio_d      = ~gnt_sel;
                if (gnt_sel) begin
                    // saturate: an all-ones counter stays put
                    if (!(&cnt1_q)) cnt1_d = cnt1_q + 1'b1;
                end else begin
                    if (!(&cnt0_q)) cnt0_d = cnt0_q + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State register; reset drops any held word so it is never presented.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
            prio_q      <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            prio_q      <= prio_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    // ------------------------------------------------------------------
    // outputs
    // ------------------------------------------------------------------
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_src   = out_src_q;
    assign bus.gnt_cnt0  = cnt0_q;
    assign bus.gnt_cnt1  = cnt1_q;

    // ------------------------------------------------------------------
    // invariants
    // ------------------------------------------------------------------

    // At most one source is accepted per cycle.
    a_one_hot_ready: assert property (@(posedge clk)
        !(bus.in0_ready && bus.in1_ready));

    // A stalled word stays put until downstream takes it.
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
        (out_valid_q && !bus.out_ready) |=>
            (out_valid_q && $stable(out_data_q) && $stable(out_src_q)));

    // A word is always taken from a source that offered one.
    a_ready_needs_valid: assert property (@(posedge clk)
        (!bus.in0_ready || bus.in0_valid) && (!bus.in1_ready || bus.in1_valid));

endmodule

// File: tb/tb_arb_2to1.sv
// Directed bench for arb_2to1: stimulus pushes expected output words into a
// queue; a monitor pops and compares each word as it leaves the arbiter.
// A second instance with 2-bit counters covers counter saturation.
module tb_arb_2to1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    arb_2to1_if #(.N(8), .CW(8)) b ();
    arb_2to1_if #(.N(8), .CW(2)) b2 ();

    arb_2to1 #(.N(8), .CW(8)) dut  (.clk(clk), .rst(rst), .bus(b));
    arb_2to1 #(.N(8), .CW(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct packed {
        logic [7:0] d;
        logic       s;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic s);
        exp_t e;
        e.d = d;
        e.s = s;
        q.push_back(e);
    endtask

    // Monitor: every word handed downstream must match the next expected one.
    always @(negedge clk) begin
        if (rst && b.out_valid && b.out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_word: got data 0x%0h src %0d with nothing expected",
                         b.out_data, b.out_src);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", {24'd0, b.out_data}, {24'd0, e.d});
                chk("out_src",  {31'd0, b.out_src},  {31'd0, e.s});
            end
        end
    end

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

        b.in0_data  = 8'h11; b.in0_valid  = 1'b1;
        b.in1_data  = 8'h22; b.in1_valid  = 1'b1;
        b.out_ready = 1'b1;
        b2.in0_data = 8'h00; b2.in0_valid = 1'b0;
        b2.in1_data = 8'h00; b2.in1_valid = 1'b0;
        b2.out_ready = 1'b1;

        // ---- reset with both sources requesting ----
        repeat (2) tick();
        chk("rst_in0_ready", {31'd0, b.in0_ready}, 0);
        chk("rst_in1_ready", {31'd0, b.in1_ready}, 0);
        chk("rst_out_valid", {31'd0, b.out_valid}, 0);
        chk("rst_out_data",  {24'd0, b.out_data},  0);
        chk("rst_out_src",   {31'd0, b.out_src},   0);
        chk("rst_cnt0",      {24'd0, b.gnt_cnt0},  0);
        chk("rst_cnt1",      {24'd0, b.gnt_cnt1},  0);
        rst = 1'b1;

        // ---- alternation ----
        for (int i = 0; i < 3; i++) begin
            push(8'h11, 1'b0);
            push(8'h22, 1'b1);
        end
        @(negedge clk);
        chk("first_gnt_in0_ready", {31'd0, b.in0_ready}, 1);
        chk("first_gnt_in1_ready", {31'd0, b.in1_ready}, 0);
        repeat (6) tick();
        b.in0_valid = 1'b0;
        b.in1_valid = 1'b0;
        tick();
        chk("alt_cnt0",      {24'd0, b.gnt_cnt0},  3);
        chk("alt_cnt1",      {24'd0, b.gnt_cnt1},  3);
        chk("alt_idle_valid", {31'd0, b.out_valid}, 0);

        // ---- backpressure ----
        b.in0_data  = 8'hA5;
        b.in0_valid = 1'b1;
        push(8'hA5, 1'b0);
        push(8'hB6, 1'b0);
        tick();
        b.out_ready = 1'b0;
        b.in0_data  = 8'hB6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_data",  {24'd0, b.out_data},  32'hA5);
            chk("stall_out_valid", {31'd0, b.out_valid}, 1);
            chk("stall_in0_ready", {31'd0, b.in0_ready}, 0);
            chk("stall_in1_ready", {31'd0, b.in1_ready}, 0);
            chk("stall_cnt0",      {24'd0, b.gnt_cnt0},  4);
            chk("stall_cnt1",      {24'd0, b.gnt_cnt1},  3);
            tick();
        end
        b.out_ready = 1'b1;
        @(negedge clk);
        chk("unstall_in0_ready", {31'd0, b.in0_ready}, 1);
        tick();
        b.in0_valid = 1'b0;
        tick();
        chk("bp_cnt0",       {24'd0, b.gnt_cnt0},  5);
        chk("bp_idle_valid", {31'd0, b.out_valid}, 0);

        // ---- fresh reset, then single source 1 ----
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst2_cnt0", {24'd0, b.gnt_cnt0}, 0);
        b.in1_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            b.in1_data = 8'(i);
            push(8'(i), 1'b1);
            tick();
        end
        b.in1_valid = 1'b0;
        tick();
        chk("single_out_valid", {31'd0, b.out_valid}, 0);
        chk("single_cnt1",      {24'd0, b.gnt_cnt1},  4);
        chk("single_cnt0",      {24'd0, b.gnt_cnt0},  0);

        // ---- counter saturation on the 2-bit instance ----
        b2.in0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b2.in0_data = 8'h40 + 8'(i);
            tick();
            chk("sat_cnt0",     {30'd0, b2.gnt_cnt0}, {30'd0, sat_exp[i]});
            chk("sat_out_data", {24'd0, b2.out_data}, 32'h40 + 32'(i));
        end
        b2.in0_valid = 1'b0;

        // ---- reset while a word is stalled in the output register ----
        b.in0_data  = 8'h5A;
        b.in0_valid = 1'b1;
        tick();
        b.out_ready = 1'b0;
        b.in0_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_out_valid", {31'd0, b.out_valid}, 1);
        chk("pre_rst_out_data",  {24'd0, b.out_data},  32'h5A);
        rst = 1'b0;
        tick();
        chk("mid_rst_out_valid", {31'd0, b.out_valid}, 0);
        chk("mid_rst_out_data",  {24'd0, b.out_data},  0);
        rst = 1'b1;
        b.out_ready = 1'b1;
        repeat (2) tick();
        chk("post_rst_out_valid", {31'd0, b.out_valid}, 0);

        // every expected word must have come out
        chk("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
